// File: rtl/acc_pkg.sv
// Shared types and arithmetic for the accumulation scheduler.
// Define ACC_RELU_EN to clamp negative sums to zero before output saturation.
package acc_pkg;

    localparam int PSUM_W = 8;
    localparam int ACC_W  = 16;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (PSUM_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic [PSUM_W-1:0] sat_relu(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] x;
        x = v;
`ifdef ACC_RELU_EN
        if (x < 0) x = '0;
`else
        x = v;
`endif
        if (x > SAT_MAX)
            x = SAT_MAX;
        else if (x < SAT_MIN)
            x = SAT_MIN;
        return PSUM_W'(x);
    endfunction

endpackage

// File: rtl/psum_buf.sv
// Partial-sum buffer: 1R1W RAM with a registered read port.
// A read and write to the same address in one cycle is resolved by the caller.
module psum_buf #(
    parameter int DEPTH = 1024,
    parameter int W     = 16,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata <= mem_q[raddr];
    end

endmodule

// File: rtl/acc_sched.sv
// Accumulates C raster-ordered psum planes of N*N pixels and emits saturated results
// on the final channel, 2 cycles after acceptance. ReLU option: ACC_RELU_EN.
module acc_sched #(
    parameter int PSUM_W = acc_pkg::PSUM_W,
    parameter int ACC_W  = acc_pkg::ACC_W,
    parameter int ADDR_W = acc_pkg::ADDR_W,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [4:0]               ofmap_size,
    input  logic [5:0]               ifmap_ch,
    input  logic signed [PSUM_W-1:0] psum,
    input  logic                     pvalid,
    output logic                     pready,
    output logic                     conv_valid,
    output logic signed [PSUM_W-1:0] conv_result,
    output logic [ADDR_W-1:0]        addr,
    output logic                     last,
    output logic                     busy,
    output logic                     done
);

    acc_pkg::state_t state_q;
    logic [ADDR_W-1:0] npix_q, pix_q;
    logic [5:0]        c_q, ch_q;
    logic              pready_q, done_q;

    // Stage 1: psum accepted last cycle, buffer data arriving now.
    logic                     s1_valid_q, s1_first_q, s1_lastch_q, s1_last_q, s1_fwd_q;
    logic [ADDR_W-1:0]        s1_addr_q;
    logic signed [PSUM_W-1:0] s1_psum_q;
    logic signed [ACC_W-1:0]  fwd_data_q;

    logic                     conv_valid_q, last_q;
    logic signed [PSUM_W-1:0] conv_result_q;
    logic [ADDR_W-1:0]        addr_q;

    logic [ADDR_W-1:0]       n_ext;
    logic                    accept, pix_last, ch_last;
    logic [ACC_W-1:0]        rdata;
    logic signed [ACC_W-1:0] base_d, sum_d;

    assign n_ext    = ADDR_W'(ofmap_size);
    assign accept   = pvalid && pready_q;
    assign pix_last = (pix_q == npix_q - ADDR_W'(1));
    assign ch_last  = (ch_q == c_q - 6'd1);

    // Channel 0 loads; otherwise use the write still in flight when it targets this pixel.
    always_comb begin
        base_d = rdata;
        if (s1_first_q)
            base_d = '0;
        else if (s1_fwd_q)
            base_d = fwd_data_q;
        sum_d = base_d + {{(ACC_W - PSUM_W){s1_psum_q[PSUM_W-1]}}, s1_psum_q};
    end

    psum_buf #(.DEPTH(DEPTH), .W(ACC_W), .AW(ADDR_W)) u_buf (
        .clk   (clk),
        .we    (s1_valid_q),
        .waddr (s1_addr_q),
        .wdata (sum_d),
        .re    (accept),
        .raddr (pix_q),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= acc_pkg::IDLE;
            npix_q        <= '0;
            pix_q         <= '0;
            c_q           <= '0;
            ch_q          <= '0;
            pready_q      <= 1'b0;
            done_q        <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_first_q    <= 1'b0;
            s1_lastch_q   <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_fwd_q      <= 1'b0;
            s1_addr_q     <= '0;
            s1_psum_q     <= '0;
            fwd_data_q    <= '0;
            conv_valid_q  <= 1'b0;
            conv_result_q <= '0;
            addr_q        <= '0;
            last_q        <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            s1_valid_q <= accept;
            if (accept) begin
                s1_addr_q   <= pix_q;
                s1_psum_q   <= psum;
                s1_first_q  <= (ch_q == 6'd0);
                s1_lastch_q <= ch_last;
                s1_last_q   <= ch_last && pix_last;
                s1_fwd_q    <= s1_valid_q && (s1_addr_q == pix_q);
            end
            if (s1_valid_q) fwd_data_q <= sum_d;

            conv_valid_q <= s1_valid_q && s1_lastch_q;
            last_q       <= s1_valid_q && s1_last_q;
            if (s1_valid_q && s1_lastch_q) begin
                conv_result_q <= acc_pkg::sat_relu(sum_d);
                addr_q        <= s1_addr_q;
            end

            case (state_q)
                acc_pkg::IDLE: begin
                    if (start) begin
                        if (ofmap_size == 5'd0 || ifmap_ch == 6'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q  <= acc_pkg::ACCUM;
                            pready_q <= 1'b1;
                            c_q      <= ifmap_ch;
                            npix_q   <= n_ext * n_ext;
                            pix_q    <= '0;
                            ch_q     <= '0;
                        end
                    end
                end
                acc_pkg::ACCUM: begin
                    if (accept) begin
                        if (pix_last) begin
                            pix_q <= '0;
                            ch_q  <= ch_q + 6'd1;
                            if (ch_last) begin
                                state_q  <= acc_pkg::FLUSH;
                                pready_q <= 1'b0;
                            end
                        end else begin
                            pix_q <= pix_q + ADDR_W'(1);
                        end
                    end
                end
                acc_pkg::FLUSH: begin
                    if (conv_valid_q && last_q) begin
                        state_q <= acc_pkg::IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= acc_pkg::IDLE;
                    pready_q <= 1'b0;
                end
            endcase
        end
    end

    assign pready      = pready_q;
    assign conv_valid  = conv_valid_q;
    assign conv_result = conv_result_q;
    assign addr        = addr_q;
    assign last        = last_q;
    assign done        = done_q;
    assign busy        = (state_q != acc_pkg::IDLE) || done_q;

endmodule

// File: tb/tb_acc_sched.sv
// Directed bench for acc_sched: scoreboard queue of {last, addr, result} checked by a
// negedge monitor, plus latency, handshake, done and reset checks.
module tb_acc_sched;

    localparam int W = 19;
`ifdef ACC_RELU_EN
    localparam int NEG_SAT = 0;
    localparam int MIX0    = 0;
`else
    localparam int NEG_SAT = -128;
    localparam int MIX0    = -15;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [4:0]        ofmap_size = '0;
    logic [5:0]        ifmap_ch = '0;
    logic signed [7:0] psum = '0;
    logic              pvalid = 1'b0;
    logic              pready, conv_valid, last, busy, done;
    logic signed [7:0] conv_result;
    logic [9:0]        addr;

    acc_sched dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ofmap_size  (ofmap_size),
        .ifmap_ch    (ifmap_ch),
        .psum        (psum),
        .pvalid      (pvalid),
        .pready      (pready),
        .conv_valid  (conv_valid),
        .conv_result (conv_result),
        .addr        (addr),
        .last        (last),
        .busy        (busy),
        .done        (done)
    );

    // clock / reset bookkeeping
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int             n_vec = 0;
    int             n_err = 0;
    logic [W-1:0]   exp_q[$];
    int             lat_q[$];
    int             last_conv_cyc = -10;
    int             job_ps[$];
    logic [W-1:0]   job_exp[$];

    function automatic logic [W-1:0] pk(input bit l, input int a, input int r);
        return {l, a[9:0], r[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && conv_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_conv_valid", {13'd0, last, addr, conv_result}, 32'h7ffff);
            end else begin
                check("conv_out", {13'd0, last, addr, conv_result}, {13'd0, exp_q.pop_front()});
                if (lat_q.size() > 0) check("latency", cyc, lat_q.pop_front() + 2);
            end
            if (last) last_conv_cyc = cyc;
        end
    end

    // driver tasks
    task automatic check_idle(input string tag);
        check({tag, "_pready"}, pready, 0);
        check({tag, "_conv_valid"}, conv_valid, 0);
        check({tag, "_conv_result"}, conv_result, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_last"}, last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic start_job(input int n, input int c);
        @(posedge clk); #1;
        ofmap_size = 5'(n);
        ifmap_ch   = 6'(c);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("pready_rise", pready, 1);
        check("busy_rise", busy, 1);
        @(posedge clk); #1;
    endtask

    task automatic send_psum(input int p, output int acc);
        int guard;
        psum   = 8'(p);
        pvalid = 1'b1;
        acc    = -1;
        guard  = 0;
        while (acc < 0 && guard < 40) begin
            @(negedge clk);
            if (pready) begin
                acc = cyc;
            end else begin
                @(posedge clk); #1;
                guard++;
            end
        end
        if (acc < 0) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        pvalid = 1'b0;
    endtask

    task automatic wait_done();
        int dc;
        dc = -1;
        for (int k = 0; k < 20 && dc < 0; k++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                check("busy_at_done", busy, 1);
            end
        end
        check("done_cycle", dc, last_conv_cyc + 1);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("all_results_seen", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input int n, input int c, input bit gap, input bit poke);
        int acc;
        int total;
        total = n * n * c;
        last_conv_cyc = -10;
        foreach (job_exp[i]) exp_q.push_back(job_exp[i]);
        start_job(n, c);
        for (int i = 0; i < total; i++) begin
            if (gap && i > 0) begin
                @(posedge clk); #1;
            end
            if (poke && i == 2) begin
                start      = 1'b1;
                ofmap_size = 5'd1;
                ifmap_ch   = 6'd1;
            end
            send_psum(job_ps[i], acc);
            start      = 1'b0;
            ofmap_size = 5'(n);
            ifmap_ch   = 6'(c);
            if (i >= total - n * n) lat_q.push_back(acc);
        end
        @(negedge clk);
        check("pready_fall", pready, 0);
        wait_done();
    endtask

    task automatic degenerate(input int n, input int c);
        bit saw_pready;
        int dc, s;
        saw_pready = 1'b0;
        dc = -1;
        @(posedge clk); #1;
        ofmap_size = 5'(n);
        ifmap_ch   = 6'(c);
        start      = 1'b1;
        s          = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pready) saw_pready = 1'b1;
            if (done && dc < 0) dc = cyc;
        end
        check("degen_pready_never", saw_pready, 0);
        check("degen_done_seen", (dc == s + 1 || dc == s + 2), 1);
        check("degen_idle", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int acc;
        bit noisy;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        job_ps  = '{1, 2, 3, 4, 10, 20, 30, 40};
        job_exp = '{pk(0, 0, 11), pk(0, 1, 22), pk(0, 2, 33), pk(1, 3, 44)};
        run_job(2, 2, 1'b0, 1'b0);

        job_ps  = '{5, 6, 7, 8};
        job_exp = '{pk(1, 0, 26)};
        run_job(1, 4, 1'b0, 1'b0);

        job_ps  = '{100, 100, 100};
        job_exp = '{pk(1, 0, 127)};
        run_job(1, 3, 1'b0, 1'b0);

        job_ps  = '{-100, -100, -100};
        job_exp = '{pk(1, 0, NEG_SAT)};
        run_job(1, 3, 1'b0, 1'b0);

        job_ps  = '{-5, 127, -128, 0, -5, 127, -128, 1, -5, -128, -128, 2};
        job_exp = '{pk(0, 0, MIX0), pk(0, 1, 126), pk(0, 2, NEG_SAT), pk(1, 3, 3)};
        run_job(2, 3, 1'b0, 1'b0);

        degenerate(2, 0);
        degenerate(0, 3);

        job_ps  = '{1, 2, 3, 4, 10, 20, 30, 40};
        job_exp = '{pk(0, 0, 11), pk(0, 1, 22), pk(0, 2, 33), pk(1, 3, 44)};
        run_job(2, 2, 1'b1, 1'b1);

        start_job(2, 2);
        send_psum(1, acc);
        send_psum(2, acc);
        send_psum(3, acc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("midjob_reset");
        noisy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (conv_valid || done || pready || busy) noisy = 1'b1;
        end
        check("quiet_after_reset", noisy, 0);

        job_ps  = '{1, 2, 3, 4, 10, 20, 30, 40};
        job_exp = '{pk(0, 0, 11), pk(0, 1, 22), pk(0, 2, 33), pk(1, 3, 44)};
        run_job(2, 2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
